// File: rtl/oled_power_seq_if.sv
// Bus bundle between the OLED power sequencer, user drawing logic, the init
// command ROM and the SPI byte engine. master = sequencer side.
interface oled_power_seq_if #(
    parameter int MAX_BYTES = 15,
    parameter int N_CMDS    = 25
);
    localparam int LEN_W  = $clog2(MAX_BYTES + 1);
    localparam int IDX_W  = (N_CMDS > 1) ? $clog2(N_CMDS) : 1;
    localparam int DATA_W = MAX_BYTES * 8;

    logic              usr_valid;
    logic              usr_ready;
    logic              usr_dc;
    logic [LEN_W-1:0]  usr_len;
    logic [DATA_W-1:0] usr_data;
    logic              usr_done;

    logic [IDX_W-1:0]  rom_idx;
    logic [LEN_W-1:0]  rom_len;
    logic [DATA_W-1:0] rom_data;

    logic              tx_start;
    logic              tx_dc;
    logic [LEN_W-1:0]  tx_len;
    logic [DATA_W-1:0] tx_data;
    logic              tx_done;

    modport master (
        input  usr_valid, usr_dc, usr_len, usr_data, rom_len, rom_data, tx_done,
        output usr_ready, usr_done, rom_idx, tx_start, tx_dc, tx_len, tx_data
    );

    modport slave (
        output usr_valid, usr_dc, usr_len, usr_data, rom_len, rom_data, tx_done,
        input  usr_ready, usr_done, rom_idx, tx_start, tx_dc, tx_len, tx_data
    );
endinterface

// File: rtl/oled_power_seq.sv
// OLED panel power lifecycle: power-up delay, reset pulse, init ROM walk with VCC ramp,
// settle, user pass-through, power-down. Optional macro OLED_SPI_TIMEOUT_EN adds an SPI watchdog.
module oled_power_seq #(
    parameter int MAX_BYTES  = 15,
    parameter int N_CMDS     = 25,
    parameter int VCC_IDX    = 23,
    parameter int PWR_CYC    = 2000000,
    parameter int RST_CYC    = 300,
    parameter int VCC_CYC    = 2500000,
    parameter int SETTLE_CYC = 10000000,
    parameter int PD_CYC     = 10000000
`ifdef OLED_SPI_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1000000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwr_on_req,
    input  logic             pwr_off_req,
    oled_power_seq_if.master bus,
    output logic             rst_out,
    output logic             vcc_en,
    output logic             pmod_en,
    output logic             active,
    output logic             fault
);
    localparam int LEN_W  = $clog2(MAX_BYTES + 1);
    localparam int IDX_W  = (N_CMDS > 1) ? $clog2(N_CMDS) : 1;
    localparam int DATA_W = MAX_BYTES * 8;

    localparam int MAX_A   = (PWR_CYC > RST_CYC) ? PWR_CYC : RST_CYC;
    localparam int MAX_B   = (MAX_A > VCC_CYC) ? MAX_A : VCC_CYC;
    localparam int MAX_C   = (MAX_B > SETTLE_CYC) ? MAX_B : SETTLE_CYC;
    localparam int CYC_MAX = (MAX_C > PD_CYC) ? MAX_C : PD_CYC;
    localparam int CNT_W   = $clog2(CYC_MAX) + 1;

    localparam logic [CNT_W-1:0]  PWR_LAST    = CNT_W'(PWR_CYC - 1);
    localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0]  VCC_LAST    = CNT_W'(VCC_CYC - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  PD_LAST     = CNT_W'(PD_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(N_CMDS - 1);
    localparam logic [IDX_W-1:0]  IDX_VCC     = IDX_W'(VCC_IDX);
    // Display-off command, sent MSB byte first.
    localparam logic [DATA_W-1:0] PD_DATA     = DATA_W'(8'hAE) << (DATA_W - 8);

    typedef enum logic [3:0] {
        S_PWR_WAIT,
        S_RST_LOW,
        S_INIT,
        S_INIT_VCC,
        S_SETTLE,
        S_ACTIVE,
        S_PD_CMD,
        S_PD_VCC,
        S_OFF
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              vcc_done_q, vcc_done_d;
    logic              busy_q, busy_d;
    logic              pend_q, pend_d;
    logic              tx_start_q, tx_start_d;
    logic              tx_dc_q, tx_dc_d;
    logic [LEN_W-1:0]  tx_len_q, tx_len_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              usr_ready_q, usr_ready_d;
    logic              usr_done_q, usr_done_d;
    logic              rst_out_q, rst_out_d;
    logic              vcc_en_q, vcc_en_d;
    logic              pmod_en_q, pmod_en_d;
    logic              active_q, active_d;

`ifdef OLED_SPI_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             fault_q, fault_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        vcc_done_d = vcc_done_q;
        busy_d     = busy_q;
        pend_d     = pend_q;
        tx_start_d = 1'b0;
        tx_dc_d    = tx_dc_q;
        tx_len_d   = tx_len_q;
        tx_data_d  = tx_data_q;
        usr_done_d = 1'b0;
        rst_out_d  = rst_out_q;
        vcc_en_d   = vcc_en_q;
        pmod_en_d  = pmod_en_q;

        if (pwr_off_req && !(state_q inside {S_PD_CMD, S_PD_VCC, S_OFF}))
            pend_d = 1'b1;

        case (state_q)
            S_PWR_WAIT: begin
                if (cnt_q == PWR_LAST) begin
                    rst_out_d = 1'b0;
                    state_d   = S_RST_LOW;
                    cnt_d     = '0;
                end
            end
            S_RST_LOW: begin
                if (cnt_q == RST_LAST) begin
                    rst_out_d = 1'b1;
                    idx_d     = '0;
                    state_d   = S_INIT;
                    cnt_d     = '0;
                end
            end
            S_INIT: begin
                if (busy_q) begin
                    if (bus.tx_done) begin
                        busy_d = 1'b0;
                        if (idx_q == IDX_LAST) begin
                            state_d = S_SETTLE;
                            cnt_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end else if (idx_q == IDX_VCC && !vcc_done_q) begin
                    vcc_en_d = 1'b1;
                    state_d  = S_INIT_VCC;
                    cnt_d    = '0;
                end else begin
                    tx_start_d = 1'b1;
                    tx_dc_d    = 1'b0;
                    tx_len_d   = bus.rom_len;
                    tx_data_d  = bus.rom_data;
                    busy_d     = 1'b1;
                end
            end
            S_INIT_VCC: begin
                // Returning to INIT with idx unchanged re-issues the same ROM entry.
                if (cnt_q == VCC_LAST) begin
                    vcc_done_d = 1'b1;
                    state_d    = S_INIT;
                    cnt_d      = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                end
            end
            S_ACTIVE: begin
                if (busy_q) begin
                    if (bus.tx_done)
                        busy_d = 1'b0;
                end else if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = S_PD_CMD;
                    cnt_d   = '0;
                end else if (bus.usr_valid && usr_ready_q) begin
                    if (bus.usr_len != '0) begin
                        tx_start_d = 1'b1;
                        tx_dc_d    = bus.usr_dc;
                        tx_len_d   = bus.usr_len;
                        tx_data_d  = bus.usr_data;
                        busy_d     = 1'b1;
                    end else begin
                        usr_done_d = 1'b1;
                    end
                end
            end
            S_PD_CMD: begin
                if (busy_q) begin
                    if (bus.tx_done) begin
                        busy_d   = 1'b0;
                        vcc_en_d = 1'b0;
                        state_d  = S_PD_VCC;
                        cnt_d    = '0;
                    end
                end else begin
                    tx_start_d = 1'b1;
                    tx_dc_d    = 1'b0;
                    tx_len_d   = LEN_W'(1);
                    tx_data_d  = PD_DATA;
                    busy_d     = 1'b1;
                end
            end
            S_PD_VCC: begin
                if (cnt_q == PD_LAST) begin
                    pmod_en_d = 1'b0;
                    rst_out_d = 1'b1;
                    state_d   = S_OFF;
                    cnt_d     = '0;
                end
            end
            S_OFF: begin
                if (pwr_on_req) begin
                    pmod_en_d  = 1'b1;
                    vcc_done_d = 1'b0;
                    state_d    = S_PWR_WAIT;
                    cnt_d      = '0;
                end
            end
            default: begin
                state_d = S_OFF;
                cnt_d   = '0;
            end
        endcase

`ifdef OLED_SPI_TIMEOUT_EN
        // Watchdog on any outstanding transfer; a stuck engine forces a hard power-off.
        fault_d = fault_q;
        tmo_d   = busy_q ? tmo_q + TMO_W'(1) : '0;
        if (busy_q && !bus.tx_done && tmo_q == TMO_LAST) begin
            fault_d    = 1'b1;
            busy_d     = 1'b0;
            pend_d     = 1'b0;
            tx_start_d = 1'b0;
            vcc_en_d   = 1'b0;
            pmod_en_d  = 1'b0;
            rst_out_d  = 1'b1;
            state_d    = S_OFF;
            cnt_d      = '0;
        end
`endif

        usr_ready_d = (state_d == S_ACTIVE) && !busy_d && !pend_d;
        active_d    = (state_d == S_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_PWR_WAIT;
            cnt_q       <= '0;
            idx_q       <= '0;
            vcc_done_q  <= 1'b0;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_dc_q     <= 1'b0;
            tx_len_q    <= '0;
            tx_data_q   <= '0;
            usr_ready_q <= 1'b0;
            usr_done_q  <= 1'b0;
            rst_out_q   <= 1'b1;
            vcc_en_q    <= 1'b0;
            pmod_en_q   <= 1'b1;
            active_q    <= 1'b0;
`ifdef OLED_SPI_TIMEOUT_EN
            tmo_q       <= '0;
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            vcc_done_q  <= vcc_done_d;
            busy_q      <= busy_d;
            pend_q      <= pend_d;
            tx_start_q  <= tx_start_d;
            tx_dc_q     <= tx_dc_d;
            tx_len_q    <= tx_len_d;
            tx_data_q   <= tx_data_d;
            usr_ready_q <= usr_ready_d;
            usr_done_q  <= usr_done_d;
            rst_out_q   <= rst_out_d;
            vcc_en_q    <= vcc_en_d;
            pmod_en_q   <= pmod_en_d;
            active_q    <= active_d;
`ifdef OLED_SPI_TIMEOUT_EN
            tmo_q       <= tmo_d;
            fault_q     <= fault_d;
`endif
        end
    end

    assign bus.rom_idx  = idx_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_dc    = tx_dc_q;
    assign bus.tx_len   = tx_len_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.usr_ready = usr_ready_q;
    // Real transfers complete with the engine's pulse; zero-length ones one cycle after accept.
    assign bus.usr_done = usr_done_q || (bus.tx_done && busy_q && state_q == S_ACTIVE);

    assign rst_out = rst_out_q;
    assign vcc_en  = vcc_en_q;
    assign pmod_en = pmod_en_q;
    assign active  = active_q;
`ifdef OLED_SPI_TIMEOUT_EN
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif
endmodule

// File: tb/tb_oled_power_seq.sv
// Directed bench for oled_power_seq with short timing parameters; each scenario task
// drives stimulus and checks against hand-computed cycle numbers.
module tb_oled_power_seq;
    localparam int MAX_BYTES  = 15;
    localparam int N_CMDS     = 4;
    localparam int VCC_IDX    = 2;
    localparam int PWR_CYC    = 10;
    localparam int RST_CYC    = 3;
    localparam int VCC_CYC    = 5;
    localparam int SETTLE_CYC = 4;
    localparam int PD_CYC     = 6;
    localparam int LEN_W      = 4;
    localparam int DATA_W     = MAX_BYTES * 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwr_on_req = 1'b0;
    logic pwr_off_req = 1'b0;
    logic rst_out, vcc_en, pmod_en, active, fault;
    int   n_cmp = 0;
    int   n_bad = 0;

    oled_power_seq_if #(.MAX_BYTES(MAX_BYTES), .N_CMDS(N_CMDS)) bus();

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rom_word(input logic [1:0] idx);
        logic [7:0] b;
        b = {6'd0, idx};
        return {8'hC0 | b, 8'h3C ^ b, 104'd0};
    endfunction

    assign bus.rom_len  = LEN_W'(bus.rom_idx) + LEN_W'(1);
    assign bus.rom_data = rom_word(bus.rom_idx);

    oled_power_seq #(
        .MAX_BYTES(MAX_BYTES), .N_CMDS(N_CMDS), .VCC_IDX(VCC_IDX), .PWR_CYC(PWR_CYC),
        .RST_CYC(RST_CYC), .VCC_CYC(VCC_CYC), .SETTLE_CYC(SETTLE_CYC), .PD_CYC(PD_CYC)
`ifdef OLED_SPI_TIMEOUT_EN
        , .TIMEOUT_CYC(20)
`endif
    ) dut (
        .clk(clk), .rst(rst), .pwr_on_req(pwr_on_req), .pwr_off_req(pwr_off_req), .bus(bus),
        .rst_out(rst_out), .vcc_en(vcc_en), .pmod_en(pmod_en), .active(active), .fault(fault)
    );

    task automatic test_reset(input string tag);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (rst_out !== 1'b1) begin n_bad++; $display("FAIL %s rst_out: got %b want 1", tag, rst_out); end
        n_cmp++; if (pmod_en !== 1'b1) begin n_bad++; $display("FAIL %s pmod_en: got %b want 1", tag, pmod_en); end
        n_cmp++; if (vcc_en !== 1'b0) begin n_bad++; $display("FAIL %s vcc_en: got %b want 0", tag, vcc_en); end
        n_cmp++; if (bus.tx_start !== 1'b0) begin n_bad++; $display("FAIL %s tx_start: got %b want 0", tag, bus.tx_start); end
        n_cmp++; if (bus.usr_ready !== 1'b0) begin n_bad++; $display("FAIL %s usr_ready: got %b want 0", tag, bus.usr_ready); end
        n_cmp++; if (bus.usr_done !== 1'b0) begin n_bad++; $display("FAIL %s usr_done: got %b want 0", tag, bus.usr_done); end
        n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL %s active: got %b want 0", tag, active); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL %s fault: got %b want 0", tag, fault); end
        n_cmp++; if (bus.rom_idx !== 2'd0) begin n_bad++; $display("FAIL %s rom_idx: got %0d want 0", tag, bus.rom_idx); end
        $display("reset %s: rst_out=%b pmod_en=%b vcc_en=%b active=%b", tag, rst_out, pmod_en, vcc_en, active);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Cycle 0 is the first cycle after the triggering edge (reset release or pwr_on_req).
    task automatic test_power_up(input string tag);
        int c_low_first = -1;
        int n_low = 0;
        int n_start = 0;
        int c_vcc = -1;
        int c_active = -1;
        int dly = 0;
        int n_ud = 0;
        int c_start[4] = '{-1, -1, -1, -1};
        int i_start[4] = '{-1, -1, -1, -1};
        int exp_start[4] = '{14, 18, 28, 32};
        for (int c = 0; c < 200 && c_active < 0; c++) begin
            @(negedge clk);
            bus.tx_done = 1'b0;
            if (c == 0) begin
                n_cmp++; if (pmod_en !== 1'b1) begin n_bad++; $display("FAIL %s pmod_en_c0: got %b want 1", tag, pmod_en); end
            end
            if (rst_out === 1'b0) begin
                if (c_low_first < 0) c_low_first = c;
                n_low++;
            end
            if (vcc_en === 1'b1 && c_vcc < 0) c_vcc = c;
            if (active === 1'b1 && c_active < 0) c_active = c;
            if (bus.tx_start === 1'b1) begin
                if (n_start < 4) begin
                    c_start[n_start] = c;
                    i_start[n_start] = int'(bus.rom_idx);
                    n_cmp++; if (bus.tx_dc !== 1'b0) begin n_bad++; $display("FAIL %s init_dc[%0d]: got %b want 0", tag, n_start, bus.tx_dc); end
                    n_cmp++; if (bus.tx_len !== LEN_W'(n_start + 1)) begin n_bad++; $display("FAIL %s init_len[%0d]: got %0d want %0d", tag, n_start, bus.tx_len, n_start + 1); end
                    n_cmp++; if (bus.tx_data !== rom_word(2'(n_start))) begin n_bad++; $display("FAIL %s init_data[%0d]: got %h want %h", tag, n_start, bus.tx_data, rom_word(2'(n_start))); end
                    $display("init %s: tx_start cycle %0d rom_idx %0d len %0d", tag, c, bus.rom_idx, bus.tx_len);
                end
                n_start++;
                dly = 2;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) bus.tx_done = 1'b1;
            end
            #1;
            if (bus.usr_done === 1'b1) n_ud++;
        end
        n_cmp++; if (c_low_first !== 10) begin n_bad++; $display("FAIL %s rst_low_start: got %0d want 10", tag, c_low_first); end
        n_cmp++; if (n_low !== RST_CYC) begin n_bad++; $display("FAIL %s rst_low_len: got %0d want %0d", tag, n_low, RST_CYC); end
        n_cmp++; if (n_start !== 4) begin n_bad++; $display("FAIL %s n_tx_start: got %0d want 4", tag, n_start); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (i_start[k] !== k) begin n_bad++; $display("FAIL %s start_idx[%0d]: got %0d want %0d", tag, k, i_start[k], k); end
            n_cmp++; if (c_start[k] !== exp_start[k]) begin n_bad++; $display("FAIL %s start_cyc[%0d]: got %0d want %0d", tag, k, c_start[k], exp_start[k]); end
        end
        n_cmp++; if (c_vcc !== 22) begin n_bad++; $display("FAIL %s vcc_rise: got %0d want 22", tag, c_vcc); end
        n_cmp++; if (!(c_vcc > c_start[1] && c_start[2] - c_vcc >= VCC_CYC)) begin n_bad++; $display("FAIL %s vcc_gap: got vcc %0d start2 %0d want gap>=%0d", tag, c_vcc, c_start[2], VCC_CYC); end
        // Last tx_done at 34, SETTLE occupies 35..38.
        n_cmp++; if (c_active !== 39) begin n_bad++; $display("FAIL %s active_cyc: got %0d want 39", tag, c_active); end
        n_cmp++; if (bus.usr_ready !== 1'b1) begin n_bad++; $display("FAIL %s ready_in_active: got %b want 1", tag, bus.usr_ready); end
        n_cmp++; if (n_ud !== 0) begin n_bad++; $display("FAIL %s init_usr_done: got %0d want 0", tag, n_ud); end
        $display("powerup %s: rst_low@%0d x%0d vcc@%0d active@%0d", tag, c_low_first, n_low, c_vcc, c_active);
    endtask

    task automatic test_user_xfer();
        logic [DATA_W-1:0] d;
        d = {24'hA1B2C3, 96'h112233445566778899AABBCC};
        @(negedge clk);
        n_cmp++; if (bus.usr_ready !== 1'b1) begin n_bad++; $display("FAIL xfer ready_before: got %b want 1", bus.usr_ready); end
        bus.usr_valid = 1'b1; bus.usr_dc = 1'b1; bus.usr_len = 4'd3; bus.usr_data = d;
        @(posedge clk);
        #1 bus.usr_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.tx_start !== 1'b1) begin n_bad++; $display("FAIL xfer tx_start: got %b want 1", bus.tx_start); end
        n_cmp++; if (bus.tx_dc !== 1'b1) begin n_bad++; $display("FAIL xfer tx_dc: got %b want 1", bus.tx_dc); end
        n_cmp++; if (bus.tx_len !== 4'd3) begin n_bad++; $display("FAIL xfer tx_len: got %0d want 3", bus.tx_len); end
        n_cmp++; if (bus.tx_data !== d) begin n_bad++; $display("FAIL xfer tx_data: got %h want %h", bus.tx_data, d); end
        n_cmp++; if (bus.usr_ready !== 1'b0) begin n_bad++; $display("FAIL xfer ready_busy: got %b want 0", bus.usr_ready); end
        @(negedge clk);
        n_cmp++; if (bus.tx_start !== 1'b0) begin n_bad++; $display("FAIL xfer start_pulse: got %b want 0", bus.tx_start); end
        n_cmp++; if (bus.usr_ready !== 1'b0) begin n_bad++; $display("FAIL xfer ready_busy2: got %b want 0", bus.usr_ready); end
        n_cmp++; if (bus.tx_data !== d) begin n_bad++; $display("FAIL xfer data_held: got %h want %h", bus.tx_data, d); end
        bus.tx_done = 1'b1;
        #1;
        n_cmp++; if (bus.usr_done !== 1'b1) begin n_bad++; $display("FAIL xfer usr_done: got %b want 1", bus.usr_done); end
        @(negedge clk);
        bus.tx_done = 1'b0;
        #1;
        n_cmp++; if (bus.usr_done !== 1'b0) begin n_bad++; $display("FAIL xfer usr_done_end: got %b want 0", bus.usr_done); end
        n_cmp++; if (bus.usr_ready !== 1'b1) begin n_bad++; $display("FAIL xfer ready_after: got %b want 1", bus.usr_ready); end
        $display("xfer: dc=1 len=3 data=%h", d);
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        bus.usr_valid = 1'b1; bus.usr_dc = 1'b1; bus.usr_len = 4'd0;
        @(posedge clk);
        #1 bus.usr_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.usr_done !== 1'b1) begin n_bad++; $display("FAIL zero usr_done: got %b want 1", bus.usr_done); end
        n_cmp++; if (bus.tx_start !== 1'b0) begin n_bad++; $display("FAIL zero tx_start: got %b want 0", bus.tx_start); end
        @(negedge clk);
        n_cmp++; if (bus.usr_done !== 1'b0) begin n_bad++; $display("FAIL zero usr_done_end: got %b want 0", bus.usr_done); end
        n_cmp++; if (bus.tx_start !== 1'b0) begin n_bad++; $display("FAIL zero tx_start2: got %b want 0", bus.tx_start); end
        $display("zero_len: usr_done pulse, no tx_start");
    endtask

    task automatic test_stray_done();
        @(negedge clk);
        bus.tx_done = 1'b1;
        #1;
        n_cmp++; if (bus.usr_done !== 1'b0) begin n_bad++; $display("FAIL stray usr_done: got %b want 0", bus.usr_done); end
        @(negedge clk);
        bus.tx_done = 1'b0;
        n_cmp++; if (bus.usr_ready !== 1'b1) begin n_bad++; $display("FAIL stray ready: got %b want 1", bus.usr_ready); end
        n_cmp++; if (bus.usr_done !== 1'b0) begin n_bad++; $display("FAIL stray usr_done2: got %b want 0", bus.usr_done); end
        $display("stray_done: ignored");
    endtask

    task automatic test_pwr_on_ignored();
        @(negedge clk);
        pwr_on_req = 1'b1;
        @(posedge clk);
        #1 pwr_on_req = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (active !== 1'b1) begin n_bad++; $display("FAIL pwr_on_active: got %b want 1", active); end
        n_cmp++; if (vcc_en !== 1'b1) begin n_bad++; $display("FAIL pwr_on_vcc: got %b want 1", vcc_en); end
        n_cmp++; if (rst_out !== 1'b1) begin n_bad++; $display("FAIL pwr_on_rst_out: got %b want 1", rst_out); end
        n_cmp++; if (bus.usr_ready !== 1'b1) begin n_bad++; $display("FAIL pwr_on_ready: got %b want 1", bus.usr_ready); end
        $display("pwr_on in ACTIVE: ignored");
    endtask

    task automatic test_power_down();
        logic [DATA_W-1:0] exp_pd;
        int found = -1;
        exp_pd = {8'hAE, 112'd0};
        @(negedge clk);
        bus.usr_valid = 1'b1; bus.usr_dc = 1'b1; bus.usr_len = 4'd2; bus.usr_data = {16'h5566, 104'd0};
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.tx_start !== 1'b1) begin n_bad++; $display("FAIL pd user_start: got %b want 1", bus.tx_start); end
        pwr_off_req = 1'b1;
        @(posedge clk);
        #1 pwr_off_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.usr_ready !== 1'b0) begin n_bad++; $display("FAIL pd ready_busy: got %b want 0", bus.usr_ready); end
        bus.tx_done = 1'b1;
        #1;
        n_cmp++; if (bus.usr_done !== 1'b1) begin n_bad++; $display("FAIL pd user_done: got %b want 1", bus.usr_done); end
        @(negedge clk);
        bus.tx_done = 1'b0;
        n_cmp++; if (bus.usr_ready !== 1'b0) begin n_bad++; $display("FAIL pd ready_pending: got %b want 0", bus.usr_ready); end
        n_cmp++; if (bus.tx_start !== 1'b0) begin n_bad++; $display("FAIL pd no_accept: got %b want 0", bus.tx_start); end
        bus.usr_valid = 1'b0;
        for (int c = 1; c <= 10 && found < 0; c++) begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) found = c;
        end
        n_cmp++; if (found !== 2) begin n_bad++; $display("FAIL pd cmd_delay: got %0d want 2", found); end
        n_cmp++; if (bus.tx_len !== 4'd1) begin n_bad++; $display("FAIL pd cmd_len: got %0d want 1", bus.tx_len); end
        n_cmp++; if (bus.tx_dc !== 1'b0) begin n_bad++; $display("FAIL pd cmd_dc: got %b want 0", bus.tx_dc); end
        n_cmp++; if (bus.tx_data !== exp_pd) begin n_bad++; $display("FAIL pd cmd_data: got %h want %h", bus.tx_data, exp_pd); end
        n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL pd active: got %b want 0", active); end
        @(negedge clk);
        @(negedge clk);
        bus.tx_done = 1'b1;
        #1;
        n_cmp++; if (bus.usr_done !== 1'b0) begin n_bad++; $display("FAIL pd no_usr_done: got %b want 0", bus.usr_done); end
        n_cmp++; if (vcc_en !== 1'b1) begin n_bad++; $display("FAIL pd vcc_before: got %b want 1", vcc_en); end
        @(negedge clk);
        bus.tx_done = 1'b0;
        n_cmp++; if (vcc_en !== 1'b0) begin n_bad++; $display("FAIL pd vcc_fall: got %b want 0", vcc_en); end
        n_cmp++; if (pmod_en !== 1'b1) begin n_bad++; $display("FAIL pd pmod_early: got %b want 1", pmod_en); end
        repeat (PD_CYC - 1) @(negedge clk);
        n_cmp++; if (pmod_en !== 1'b1) begin n_bad++; $display("FAIL pd pmod_hold: got %b want 1", pmod_en); end
        @(negedge clk);
        n_cmp++; if (pmod_en !== 1'b0) begin n_bad++; $display("FAIL pd pmod_fall: got %b want 0", pmod_en); end
        n_cmp++; if (rst_out !== 1'b1) begin n_bad++; $display("FAIL pd off_rst_out: got %b want 1", rst_out); end
        n_cmp++; if (bus.usr_ready !== 1'b0) begin n_bad++; $display("FAIL pd off_ready: got %b want 0", bus.usr_ready); end
        $display("power_down: 0xAE sent, vcc_en then pmod_en dropped");
    endtask

    task automatic test_repower();
        @(negedge clk);
        pwr_on_req = 1'b1;
        @(posedge clk);
        #1 pwr_on_req = 1'b0;
        test_power_up("repower");
    endtask

`ifdef OLED_SPI_TIMEOUT_EN
    task automatic test_timeout();
        int c_start = -1;
        int c_fault = -1;
        for (int c = 0; c < 100 && c_fault < 0; c++) begin
            @(negedge clk);
            if (bus.tx_start === 1'b1 && c_start < 0) c_start = c;
            if (fault === 1'b1 && c_fault < 0) c_fault = c;
        end
        n_cmp++; if (c_start !== 14) begin n_bad++; $display("FAIL tmo start_cyc: got %0d want 14", c_start); end
        n_cmp++; if (c_fault !== 34) begin n_bad++; $display("FAIL tmo fault_cyc: got %0d want 34", c_fault); end
        n_cmp++; if (vcc_en !== 1'b0) begin n_bad++; $display("FAIL tmo vcc_en: got %b want 0", vcc_en); end
        n_cmp++; if (pmod_en !== 1'b0) begin n_bad++; $display("FAIL tmo pmod_en: got %b want 0", pmod_en); end
        $display("timeout: fault@%0d", c_fault);
        test_reset("after_fault");
    endtask
`endif

    initial begin
        bus.usr_valid = 1'b0;
        bus.usr_dc    = 1'b0;
        bus.usr_len   = '0;
        bus.usr_data  = '0;
        bus.tx_done   = 1'b0;
        test_reset("por");
        test_power_up("first");
        test_user_xfer();
        test_zero_len();
        test_stray_done();
        test_pwr_on_ignored();
        test_power_down();
        test_repower();
        test_reset("mid");
`ifdef OLED_SPI_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/oled_power_seq.md
Name: oled_power_seq

Overview:
- Parametrised OLED panel controller that owns the full power lifecycle: power-up delay, reset pulse, init-command walk, VCC ramp, settle, active pass-through, and a controlled power-down back to OFF with re-power on request.
- Sits between user drawing logic and the SPI byte engine. It drives the engine through a start/done handshake and reads init commands from an external command ROM by index.
- Generalises the fixed 25-command / fixed-delay startup to configurable timing, configurable ROM depth, a power-down sequence and a valid/ready user interface.

Parameters:
- MAX_BYTES, 15, maximum bytes per transfer; payload width is MAX_BYTES*8.
- N_CMDS, 25, number of init ROM entries (indices 0..N_CMDS-1).
- VCC_IDX, 23, ROM index before which vcc_en rises and VCC_CYC is waited.
- PWR_CYC, 2000000, cycles from pmod_en high to reset assertion.
- RST_CYC, 300, cycles rst_out is held low.
- VCC_CYC, 2500000, VCC ramp wait.
- SETTLE_CYC, 10000000, wait after last init command before ACTIVE.
- PD_CYC, 10000000, wait after vcc_en falls before pmod_en falls.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pwr_on_req  in  1  pulse; restart power-up from OFF
- pwr_off_req  in  1  pulse; request power-down
- usr_valid  in  1  user transfer request
- usr_ready  out  1  transfer accepted when valid&ready
- usr_dc  in  1  0=command, 1=data
- usr_len  in  $clog2(MAX_BYTES+1)  byte count
- usr_data  in  MAX_BYTES*8  payload, MSB byte first
- usr_done  out  1  pulse when user transfer completes
- rom_idx  out  $clog2(N_CMDS)  init ROM address
- rom_len  in  $clog2(MAX_BYTES+1)  ROM entry length (combinational read)
- rom_data  in  MAX_BYTES*8  ROM entry payload
- tx_start  out  1  one-cycle start to SPI engine
- tx_dc, tx_len, tx_data  out  1 / len width / MAX_BYTES*8  registered transfer fields, held until tx_done
- tx_done  in  1  engine completion pulse
- rst_out  out  1  panel reset, active-low
- vcc_en, pmod_en  out  1  panel supply enables
- active  out  1  high in ACTIVE
- fault  out  1  sticky error (optional feature only)

Behaviour:
- Reset values: rst_out=1, pmod_en=1, vcc_en=0, tx_start=0, usr_ready=0, usr_done=0, active=0, fault=0, rom_idx=0, counter=0. State after reset is PWR_WAIT.
- PWR_WAIT: count PWR_CYC cycles, then rst_out=0 and go to RST_LOW.
- RST_LOW: rst_out stays low for exactly RST_CYC cycles, then rst_out=1 and go to INIT with idx=0.
- INIT:
  - If idx==VCC_IDX and the VCC wait is not yet done: set vcc_en=1, wait VCC_CYC cycles, mark the wait done, then resume without advancing idx.
  - Otherwise issue tx_start with dc=0 and the ROM fields, wait for tx_done, then idx++.
  - After idx N_CMDS-1 completes, go to SETTLE.
- SETTLE: wait SETTLE_CYC cycles, then go to ACTIVE.
- ACTIVE:
  - usr_ready=1 only when no transfer is outstanding and no power-off is pending.
  - On accept in cycle N: fields are registered and tx_start=1 in cycle N+1; usr_ready=0 until tx_done.
  - usr_done=tx_done in the same cycle.
  - usr_len=0: accept, no tx_start, usr_done pulses in cycle N+1.
- Power-down:
  - pwr_off_req in any state except OFF/PD_* sets a pending flag. It is acted on only in ACTIVE, once no transfer is outstanding.
  - If usr_valid and a pending power-off coincide, power-off wins and usr_ready is 0.
  - PD_CMD: tx_start with dc=0, len=1, data MSB byte 0xAE; wait tx_done.
  - PD_VCC: vcc_en=0, wait PD_CYC cycles.
  - OFF: pmod_en=0, rst_out=1, active=0.
- pwr_on_req is honoured only in OFF: pmod_en=1, VCC-wait flag cleared, go to PWR_WAIT. It is ignored in all other states.
- tx_done arriving with no outstanding transfer is ignored.
- Reset mid-operation returns to reset values immediately; no power-down command is sent.
- Counters are sized $clog2 of the largest CYC parameter plus 1 and cleared on every state change.
- usr_done never pulses for init or power-down transfers.

Optional Feature:
- Macro OLED_SPI_TIMEOUT_EN; parameter TIMEOUT_CYC, default 1000000.
- With it: if tx_done does not arrive within TIMEOUT_CYC cycles of tx_start, set fault=1 (sticky until rst), drop vcc_en, and go to OFF.
- Without it: waits indefinitely and fault is tied to 0.

Test Plan:
- Params PWR_CYC=10, RST_CYC=3, VCC_CYC=5, SETTLE_CYC=4, N_CMDS=4, VCC_IDX=2, tx_done 2 cycles after each tx_start, rst deasserted at t=0 -> rst_out low exactly 3 cycles starting at cycle 10; exactly 4 tx_start pulses with rom_idx 0,1,2,3; vcc_en rises before idx 2 and that tx_start follows ≥5 cycles later; active=1 4 cycles after the 4th tx_done.
- ACTIVE, usr_valid with dc=1, len=3, data=0xA1B2C3… -> tx_start the next cycle with tx_dc=1, tx_len=3, identical tx_data; usr_ready=0 until tx_done; usr_done coincides with tx_done.
- pwr_off_req during an outstanding user transfer -> no new accept; after tx_done, tx_start with len=1 and data MSB byte 0xAE; vcc_en falls at that tx_done; pmod_en falls PD_CYC cycles later.
- pwr_on_req in OFF -> pmod_en=1 and the full sequence repeats with 4 init commands. The same pulse in ACTIVE -> no effect.
- usr_len=0 accept -> no tx_start, usr_done the next cycle. A stray tx_done in ACTIVE while idle -> no usr_done.
- With OLED_SPI_TIMEOUT_EN and TIMEOUT_CYC=20, tx_done withheld in INIT -> fault=1 at cycle 20 after tx_start, vcc_en=0, pmod_en=0. rst clears fault.
